// File: rtl/da_lut_loader.sv
// da_lut_loader: builds the distributed-arithmetic LUT for fir_filter from a
// host-written coefficient bank and streams it out one entry per clock.
//
// Ports:
//   clk_slow   - loader clock (fir_filter LUT-load clock)
//   resetn     - asynchronous active-low reset
//   coef_we    - coefficient write strobe (ignored while busy)
//   coef_addr  - coefficient index, tap = group*8 + bit
//   coef_din   - signed coefficient value
//   start      - single-cycle request for a full LUT load
//   cin        - signed LUT entry value (to fir_filter CIN)
//   caddr      - LUT entry address {group, pattern} (to CADDR)
//   cload      - cin/caddr hold a valid entry (to CLOAD)
//   busy       - load in progress
//   done       - one-cycle pulse after the last entry
module da_lut_loader #(
  parameter int unsigned NGROUP = 8,
  parameter int unsigned CW     = 16,
  parameter int unsigned LW     = 19
) (
  input  logic                           clk_slow,
  input  logic                           resetn,
  input  logic                           coef_we,
  input  logic [$clog2(NGROUP*8)-1:0]    coef_addr,
  input  logic [CW-1:0]                  coef_din,
  input  logic                           start,
  output logic [LW-1:0]                  cin,
  output logic [$clog2(NGROUP)+7:0]      caddr,
  output logic                           cload,
  output logic                           busy,
  output logic                           done
);

  localparam int unsigned NTAPS = NGROUP * 8;
  localparam int unsigned AW    = $clog2(NTAPS);
  localparam int unsigned GW    = $clog2(NGROUP);
  localparam int unsigned PW    = 8;
  localparam int unsigned FW    = 3;
  localparam int unsigned XW    = GW + PW;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_EMIT  = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  state_e          state_q, state_d;
  logic [GW-1:0]   group_q, group_d;
  logic [FW-1:0]   f_q, f_d;
  logic [PW-1:0]   pat_q, pat_d;
  logic [CW-1:0]   w_q [8];
  logic [CW-1:0]   w_d [8];
  logic [LW-1:0]   cin_q, cin_d;
  logic [XW-1:0]   caddr_q, caddr_d;
  logic            cload_q, cload_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;

  logic [CW-1:0]   coef_q [NTAPS];
  logic [LW-1:0]   sum_c;

  // Coefficient bank: host writes land only while no load is running.
  always_ff @(posedge clk_slow or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < int'(NTAPS); i++) begin
        coef_q[i] <= '0;
      end
    end else if (coef_we && !busy_q) begin
      coef_q[coef_addr] <= coef_din;
    end
  end

  // DA partial sum for the current bit pattern over the 8 latched taps.
  always_comb begin
    sum_c = '0;
    for (int b = 0; b < 8; b++) begin
      if (pat_q[b]) begin
        sum_c = sum_c + {{(LW-CW){w_q[b][CW-1]}}, w_q[b]};
      end
    end
  end

  // Next-state and registered-output logic.
  always_comb begin
    state_d = state_q;
    group_d = group_q;
    f_d     = f_q;
    pat_d   = pat_q;
    w_d     = w_q;
    cin_d   = cin_q;
    caddr_d = caddr_q;
    cload_d = 1'b0;
    busy_d  = busy_q;
    done_d  = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        busy_d = 1'b0;
        if (start) begin
          state_d = ST_FETCH;
          group_d = '0;
          f_d     = '0;
          busy_d  = 1'b1;
        end
      end

      ST_FETCH: begin
        w_d[f_q] = coef_q[AW'({group_q, f_q})];
        f_d      = f_q + FW'(1);
        if (f_q == FW'(7)) begin
          state_d = ST_EMIT;
          pat_d   = '0;
        end
      end

      ST_EMIT: begin
        cin_d   = sum_c;
        caddr_d = {group_q, pat_q};
        cload_d = 1'b1;
        pat_d   = pat_q + PW'(1);
        if (pat_q == PW'(255)) begin
          if (group_q == GW'(NGROUP - 1)) begin
            state_d = ST_DONE;
          end else begin
            group_d = group_q + GW'(1);
            f_d     = '0;
            state_d = ST_FETCH;
          end
        end
      end

      ST_DONE: begin
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk_slow or negedge resetn) begin
    if (!resetn) begin
      state_q <= ST_IDLE;
      group_q <= '0;
      f_q     <= '0;
      pat_q   <= '0;
      for (int i = 0; i < 8; i++) begin
        w_q[i] <= '0;
      end
      cin_q   <= '0;
      caddr_q <= '0;
      cload_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      group_q <= group_d;
      f_q     <= f_d;
      pat_q   <= pat_d;
      w_q     <= w_d;
      cin_q   <= cin_d;
      caddr_q <= caddr_d;
      cload_q <= cload_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign cin   = cin_q;
  assign caddr = caddr_q;
  assign cload = cload_q;
  assign busy  = busy_q;
  assign done  = done_q;

endmodule

// File: tb/tb_da_lut_loader.sv
// Self-checking bench for da_lut_loader: directed table checks plus randomized
// coefficient sets checked against an arithmetic LUT model.
module tb_da_lut_loader;

  logic        clk_slow  = 1'b0;
  logic        resetn    = 1'b0;
  logic        coef_we   = 1'b0;
  logic [5:0]  coef_addr = '0;
  logic [15:0] coef_din  = '0;
  logic        start     = 1'b0;
  logic [18:0] cin;
  logic [10:0] caddr;
  logic        cload;
  logic        busy;
  logic        done;

  da_lut_loader dut (
    .clk_slow  (clk_slow),
    .resetn    (resetn),
    .coef_we   (coef_we),
    .coef_addr (coef_addr),
    .coef_din  (coef_din),
    .start     (start),
    .cin       (cin),
    .caddr     (caddr),
    .cload     (cload),
    .busy      (busy),
    .done      (done)
  );

  always #5 clk_slow = ~clk_slow;

  int tests = 0;
  int fails = 0;
  int mcoef [64];
  int cap   [2048];

  typedef struct {
    int mode;
    int addr;
    int exp;
  } vec_t;
  vec_t tbl [10];

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // LUT entry = sum of the group's coefficients selected by the pattern bits.
  function automatic int model_cin(input int a);
    int g;
    int s;
    g = a / 256;
    s = 0;
    for (int b = 0; b < 8; b++) begin
      if (((a >> b) & 1) == 1) s += mcoef[g * 8 + b];
    end
    return s;
  endfunction

  task automatic wr(input int a, input int v);
    @(negedge clk_slow);
    coef_we   = 1'b1;
    coef_addr = 6'(a);
    coef_din  = 16'(v);
    @(negedge clk_slow);
    coef_we   = 1'b0;
    mcoef[a]  = v;
  endtask

  function automatic int rnd_coef();
    return int'($urandom_range(0, 65535)) - 32768;
  endfunction

  task automatic check_table(input int mode);
    for (int i = 0; i < 10; i++) begin
      if (tbl[i].mode == mode) begin
        check($sformatf("tbl_m%0d_%03h", mode, tbl[i].addr), cap[tbl[i].addr], tbl[i].exp);
      end
    end
  endtask

  // Start a load at edge 0 and follow it edge by edge.
  task automatic run_load(input string tag, input bit same_wr, input bit poke, input int abort_at);
    int n_cl, err, exp_a, first_e, last_e, done_e, done_n, busy_fall, extra, sa, sv;
    bit gap_ok, aborted;
    n_cl = 0; err = 0; exp_a = 0; first_e = -1; last_e = -1; done_e = -1;
    done_n = 0; busy_fall = -1; extra = 0; gap_ok = 1'b1; aborted = 1'b0;
    @(negedge clk_slow);
    start = 1'b1;
    if (same_wr) begin
      sa = int'($urandom_range(0, 7));
      sv = rnd_coef();
      coef_we   = 1'b1;
      coef_addr = 6'(sa);
      coef_din  = 16'(sv);
      mcoef[sa] = sv;
    end
    @(posedge clk_slow);
    #1;
    start   = 1'b0;
    coef_we = 1'b0;
    check({tag, "_busy_rise"}, int'(busy), 1);
    for (int e = 1; e <= 2130; e++) begin
      @(posedge clk_slow);
      #1;
      if (cload) begin
        n_cl++;
        if (exp_a < 2048) begin
          if (int'(caddr) != exp_a || int'($signed(cin)) != model_cin(exp_a)) err++;
          cap[exp_a] = int'($signed(cin));
        end else begin
          err++;
        end
        exp_a++;
        if (first_e < 0) first_e = e;
        last_e = e;
      end
      if (done) begin
        done_n++;
        if (done_e < 0) done_e = e;
      end
      if (busy_fall < 0 && !busy) busy_fall = e;
      if (e >= 265 && e <= 272 && cload) gap_ok = 1'b0;
      if (e == 273 && !(cload && caddr == 11'h100)) gap_ok = 1'b0;
      if (poke && e == 100) begin
        start     = 1'b1;
        coef_we   = 1'b1;
        coef_addr = 6'd0;
        coef_din  = 16'h1234;
      end
      if (poke && e == 101) begin
        start   = 1'b0;
        coef_we = 1'b0;
      end
      if (e == abort_at) begin
        #2 resetn = 1'b0;
        #1;
        check({tag, "_rst_cload"}, int'(cload), 0);
        check({tag, "_rst_busy"}, int'(busy), 0);
        check({tag, "_rst_done"}, int'(done), 0);
        for (int k = 0; k < 64; k++) mcoef[k] = 0;
        for (int k = 0; k < 4; k++) begin
          @(posedge clk_slow);
          #1;
          if (cload || busy) extra++;
        end
        check({tag, "_rst_quiet"}, extra, 0);
        @(negedge clk_slow);
        resetn  = 1'b1;
        aborted = 1'b1;
        break;
      end
    end
    if (!aborted) begin
      check({tag, "_n_cload"}, n_cl, 2048);
      check({tag, "_entry_errs"}, err, 0);
      check({tag, "_first_edge"}, first_e, 9);
      check({tag, "_last_edge"}, last_e, 2112);
      check({tag, "_done_edge"}, done_e, 2113);
      check({tag, "_done_count"}, done_n, 1);
      check({tag, "_busy_fall"}, busy_fall, 2113);
      check({tag, "_gap"}, int'(gap_ok), 1);
    end
  endtask

  initial begin
    tbl[0] = '{1, 'h0FF, 8};
    tbl[1] = '{1, 'h000, 0};
    tbl[2] = '{1, 'h123, 3};
    tbl[3] = '{2, 'h2FF, 164};
    tbl[4] = '{2, 'h005, 4};
    tbl[5] = '{2, 'h700, 0};
    tbl[6] = '{3, 'h0FF, -262144};
    tbl[7] = '{3, 'h7FF, -262144};
    tbl[8] = '{3, 'h080, -32768};
    tbl[9] = '{3, 'h3FE, -229376};
    for (int k = 0; k < 64; k++) mcoef[k] = 0;

    // Reset state
    #12;
    check("rst_cin", int'(cin), 0);
    check("rst_caddr", int'(caddr), 0);
    check("rst_cload", int'(cload), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_done", int'(done), 0);
    @(negedge clk_slow);
    resetn = 1'b1;

    // All ones: cin equals the popcount of the pattern
    for (int t = 0; t < 64; t++) wr(t, 1);
    run_load("ones", 1'b0, 1'b0, 0);
    check_table(1);

    // Ramp coefficients, with a write and a start poked while busy
    for (int t = 0; t < 64; t++) wr(t, t + 1);
    run_load("ramp", 1'b0, 1'b1, 0);
    check_table(2);
    run_load("ramp2", 1'b0, 1'b0, 0);
    check("coef0_kept", cap[1], 1);

    // Most negative coefficients everywhere
    for (int t = 0; t < 64; t++) wr(t, -32768);
    run_load("neg", 1'b0, 1'b0, 0);
    check_table(3);

    // Most positive extreme
    for (int t = 0; t < 64; t++) wr(t, 32767);
    run_load("pos", 1'b0, 1'b0, 0);
    check("pos_7ff", cap['h7FF], 262136);

    // Random sets, second one with a write coincident with start
    for (int r = 0; r < 2; r++) begin
      for (int t = 0; t < 64; t++) wr(t, rnd_coef());
      run_load($sformatf("rnd%0d", r), r == 1, 1'b0, 0);
    end

    // Reset mid-load, then bank must be cleared, then a fresh load works
    run_load("abort", 1'b0, 1'b0, 500);
    run_load("cleared", 1'b0, 1'b0, 0);
    for (int t = 0; t < 64; t++) wr(t, rnd_coef());
    run_load("after_rst", 1'b1, 1'b0, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
